// File: rtl/fft_pkg.sv
// Shared types and sizes for the FFT output-stream consumers.
// The result word packs {real, imag} with real in the upper half.
package fft_pkg;

  localparam int OWIDTH  = 11;
  localparam int LGWIDTH = 4;
  localparam int N       = 2 ** LGWIDTH;

  typedef enum logic {
    W_IDLE,
    W_FILL
  } wstate_t;

  typedef enum logic {
    R_IDLE,
    R_STREAM
  } rstate_t;

  typedef struct packed {
    logic [OWIDTH-1:0] re;
    logic [OWIDTH-1:0] im;
  } result_t;

endpackage

// File: rtl/fft_capture_bank.sv
// Simple dual-port frame store: one write port, one registered read port.
// Address is {bank, bin}; read data holds its value while rd_en is low.
module fft_capture_bank #(
  parameter int DW = 22,
  parameter int AW = 5
) (
  input  logic          i_clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [2**AW];

  // NOTE: the array has no reset; validity is tracked by the bank full flags,
  // and leaving it out keeps the array mappable onto block RAM.
  always_ff @(posedge i_clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/fft_frame_capture.sv
// Captures sync-aligned 16-bin FFT frames into a ping-pong buffer and drains
// them in bin order over valid/ready; frames arriving with no free bank are dropped.
module fft_frame_capture
  import fft_pkg::*;
#(
  parameter int OWIDTH  = fft_pkg::OWIDTH,
  parameter int LGWIDTH = fft_pkg::LGWIDTH,
  parameter int CNTW    = 16
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_ce,
  input  logic [2*OWIDTH-1:0]  i_result,
  input  logic                 i_sync,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [2*OWIDTH-1:0]  o_data,
  output logic [LGWIDTH-1:0]   o_bin,
  output logic                 o_last,
  output logic                 o_overflow,
  output logic [CNTW-1:0]      o_drop_count
);

  localparam int                 DW       = 2 * OWIDTH;
  localparam int                 NBIN     = 1 << LGWIDTH;
  localparam logic [LGWIDTH-1:0] LAST_BIN = LGWIDTH'(NBIN - 1);

  // ---------------------------------------------------------------------------
  // Shared state
  // ---------------------------------------------------------------------------
  logic [1:0] full;
  logic       wb, rb;
  logic       set_full, clr_full;

  // ---------------------------------------------------------------------------
  // Write side
  // ---------------------------------------------------------------------------
  wstate_t            wstate, wstate_nxt;
  logic [LGWIDTH-1:0] wptr, wptr_nxt;
  logic [LGWIDTH-1:0] wr_bin;
  logic               wb_nxt;
  logic               wr_en;
  logic               drop;

  // NOTE: every output of this block gets a default first, so no path
  // through the case statement can leave a signal unassigned and infer a latch.
  always_comb begin
    wstate_nxt = wstate;
    wptr_nxt   = wptr;
    wb_nxt     = wb;
    wr_en      = 1'b0;
    wr_bin     = wptr;
    set_full   = 1'b0;
    drop       = 1'b0;
    case (wstate)
      W_IDLE: begin
        if (i_ce && i_sync) begin
          if (!full[wb]) begin
            wr_en      = 1'b1;
            wr_bin     = '0;
            wptr_nxt   = LGWIDTH'(1);
            wstate_nxt = W_FILL;
          end else begin
            drop = 1'b1;
          end
        end
      end
      W_FILL: begin
        if (i_ce) begin
          wr_en = 1'b1;
          if (i_sync) begin
            // Early sync: restart the frame in place, overwriting the partial one.
            wr_bin   = '0;
            wptr_nxt = LGWIDTH'(1);
          end else if (wptr == LAST_BIN) begin
            set_full   = 1'b1;
            wb_nxt     = ~wb;
            wptr_nxt   = '0;
            wstate_nxt = W_IDLE;
          end else begin
            wptr_nxt = wptr + 1'b1;
          end
        end
      end
      default: wstate_nxt = W_IDLE;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every register samples the pre-edge value of every other register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wstate       <= W_IDLE;
      wptr         <= '0;
      wb           <= 1'b0;
      o_overflow   <= 1'b0;
      o_drop_count <= '0;
    end else begin
      wstate     <= wstate_nxt;
      wptr       <= wptr_nxt;
      wb         <= wb_nxt;
      o_overflow <= drop;
      if (drop && (o_drop_count != {CNTW{1'b1}}))
        o_drop_count <= o_drop_count + CNTW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Frame store
  // ---------------------------------------------------------------------------
  logic                rd_en;
  logic [LGWIDTH:0]    rptr, rptr_nxt;
  logic [DW-1:0]       rd_data;

  fft_capture_bank #(
    .DW (DW),
    .AW (LGWIDTH + 1)
  ) u_bank (
    .i_clk   (i_clk),
    .wr_en   (wr_en),
    .wr_addr ({wb, wr_bin}),
    .wr_data (i_result),
    .rd_en   (rd_en),
    .rd_addr ({rb, rptr[LGWIDTH-1:0]}),
    .rd_data (rd_data)
  );

  // ---------------------------------------------------------------------------
  // Read side: RAM read stage -> skid -> output register
  // ---------------------------------------------------------------------------
  rstate_t            rstate, rstate_nxt;
  logic               rb_nxt;
  logic               rd_pend;
  logic [LGWIDTH-1:0] rd_bin;
  logic               rd_last;
  logic               skid_valid;
  logic [DW-1:0]      skid_data;
  logic [LGWIDTH-1:0] skid_bin;
  logic               skid_last;
  logic               out_free, take, skid_fill, can_issue;

  // A read may be issued only if its data is guaranteed a slot next cycle;
  // the skid and an in-flight read are therefore never occupied together.
  always_comb begin
    out_free  = !o_valid || i_ready;
    take      = o_valid && i_ready;
    skid_fill = !out_free && (skid_valid || rd_pend);
    can_issue = !skid_fill;
  end

  always_comb begin
    rstate_nxt = rstate;
    rptr_nxt   = rptr;
    rb_nxt     = rb;
    rd_en      = 1'b0;
    clr_full   = 1'b0;
    case (rstate)
      R_IDLE: begin
        if (full[rb] && can_issue) begin
          rd_en      = 1'b1;
          rptr_nxt   = (LGWIDTH + 1)'(1);
          rstate_nxt = R_STREAM;
        end
      end
      R_STREAM: begin
        if (!rptr[LGWIDTH] && can_issue) begin
          rd_en    = 1'b1;
          rptr_nxt = rptr + 1'b1;
        end
        if (take && o_last) begin
          clr_full   = 1'b1;
          rb_nxt     = ~rb;
          rptr_nxt   = '0;
          rstate_nxt = R_IDLE;
        end
      end
      default: rstate_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rstate     <= R_IDLE;
      rptr       <= '0;
      rb         <= 1'b0;
      full       <= '0;
      rd_pend    <= 1'b0;
      rd_bin     <= '0;
      rd_last    <= 1'b0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      skid_bin   <= '0;
      skid_last  <= 1'b0;
      o_valid    <= 1'b0;
      o_data     <= '0;
      o_bin      <= '0;
      o_last     <= 1'b0;
    end else begin
      rstate <= rstate_nxt;
      rptr   <= rptr_nxt;
      rb     <= rb_nxt;
      // Set and clear always target different banks, so both apply.
      if (clr_full) full[rb] <= 1'b0;
      if (set_full) full[wb] <= 1'b1;

      rd_pend <= rd_en;
      if (rd_en) begin
        rd_bin  <= rptr[LGWIDTH-1:0];
        rd_last <= (rptr[LGWIDTH-1:0] == LAST_BIN);
      end

      skid_valid <= skid_fill;
      if (!out_free && rd_pend) begin
        skid_data <= rd_data;
        skid_bin  <= rd_bin;
        skid_last <= rd_last;
      end

      if (out_free) begin
        o_valid <= skid_valid || rd_pend;
        if (skid_valid) begin
          o_data <= skid_data;
          o_bin  <= skid_bin;
          o_last <= skid_last;
        end else if (rd_pend) begin
          o_data <= rd_data;
          o_bin  <= rd_bin;
          o_last <= rd_last;
        end
      end
    end
  end

endmodule

// File: tb/tb_fft_frame_capture.sv
// Scoreboard bench for fft_frame_capture: expected beats are queued as samples
// are driven and compared as the DUT hands them off on o_valid && i_ready.
`timescale 1ns/1ps
module tb_fft_frame_capture;
  import fft_pkg::*;

  localparam int CNTW = 16;
  localparam int DW   = 2 * OWIDTH;

  logic                clk = 1'b0;
  logic                i_reset, i_ce, i_sync, i_ready;
  logic [DW-1:0]       i_result;
  logic                o_valid, o_last, o_overflow;
  logic [DW-1:0]       o_data;
  logic [LGWIDTH-1:0]  o_bin;
  logic [CNTW-1:0]     o_drop_count;

  always #5 clk = ~clk;

  fft_frame_capture #(
    .OWIDTH  (OWIDTH),
    .LGWIDTH (LGWIDTH),
    .CNTW    (CNTW)
  ) dut (
    .i_clk        (clk),
    .i_reset      (i_reset),
    .i_ce         (i_ce),
    .i_result     (i_result),
    .i_sync       (i_sync),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_data       (o_data),
    .o_bin        (o_bin),
    .o_last       (o_last),
    .o_overflow   (o_overflow),
    .o_drop_count (o_drop_count)
  );

  typedef struct {
    logic [DW-1:0]      data;
    logic [LGWIDTH-1:0] bin;
    logic               last;
  } beat_t;

  beat_t              exp_q[$];
  int                 n_checks  = 0;
  int                 n_fail    = 0;
  int                 ovf_seen  = 0;
  int                 exp_drops = 0;
  bit                 rand_ready = 1'b0;
  bit                 held_valid = 1'b0;
  bit                 in_frame   = 1'b0;
  beat_t              held;
  bit                 last_valid, last_acc;
  logic [LGWIDTH-1:0] last_acc_bin;

  function automatic logic [DW-1:0] make_word(input int fid, input int bin);
    result_t w;
    w.re = OWIDTH'(fid * N + bin);
    w.im = ~OWIDTH'(fid * N + bin);
    return w;
  endfunction

  // One clock: sample and score outputs at the falling edge, then advance.
  task automatic clock_cycle();
    beat_t e;
    @(negedge clk);
    last_valid = o_valid;
    last_acc   = o_valid && i_ready;
    if (o_overflow === 1'b1) ovf_seen++;
    if (held_valid) begin
      n_checks++;
      if (o_valid !== 1'b1 || o_data !== held.data || o_bin !== held.bin || o_last !== held.last) begin
        n_fail++;
        $display("FAIL stall_hold: got v=%b d=%h bin=%0d last=%b, want v=1 d=%h bin=%0d last=%b",
                 o_valid, o_data, o_bin, o_last, held.data, held.bin, held.last);
      end
    end else if (in_frame) begin
      n_checks++;
      if (o_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL mid_frame_valid: got o_valid=%b, want 1", o_valid);
      end
    end
    if (o_valid === 1'b1 && i_ready === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_beat: got bin=%0d d=%h, want no beat", o_bin, o_data);
      end else begin
        e = exp_q.pop_front();
        if (o_data !== e.data || o_bin !== e.bin || o_last !== e.last) begin
          n_fail++;
          $display("FAIL beat: got d=%h bin=%0d last=%b, want d=%h bin=%0d last=%b",
                   o_data, o_bin, o_last, e.data, e.bin, e.last);
        end
      end
      last_acc_bin = o_bin;
      in_frame     = !o_last;
    end
    held_valid = (o_valid === 1'b1) && (i_ready !== 1'b1);
    held.data  = o_data;
    held.bin   = o_bin;
    held.last  = o_last;
    @(posedge clk);
    #1;
    if (rand_ready) i_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send_sample(input int fid, input int bin, input bit sync, input bit push);
    beat_t e;
    i_ce     = 1'b1;
    i_sync   = sync;
    i_result = make_word(fid, bin);
    if (push) begin
      e.data = make_word(fid, bin);
      e.bin  = LGWIDTH'(bin);
      e.last = (bin == N - 1);
      exp_q.push_back(e);
    end
    clock_cycle();
  endtask

  // Disabled-CE cycle with junk data and sync to prove both are ignored.
  task automatic idle_cycle();
    i_ce     = 1'b0;
    i_sync   = 1'($urandom_range(0, 1));
    i_result = DW'($urandom);
    clock_cycle();
  endtask

  task automatic send_frame(input int fid, input bit gap, input bit push);
    for (int b = 0; b < N; b++) begin
      send_sample(fid, b, b == 0, push);
      if (gap && b != N - 1) idle_cycle();
    end
    i_ce   = 1'b0;
    i_sync = 1'b0;
  endtask

  task automatic drain(input int max_cycles, input string name);
    int cnt = 0;
    while (exp_q.size() != 0 && cnt < max_cycles) begin
      clock_cycle();
      cnt++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain_timeout: got %0d beats outstanding, want 0", name, exp_q.size());
    end
    repeat (4) clock_cycle();
  endtask

  task automatic test_reset();
    i_reset  = 1'b1;
    i_ce     = 1'b0;
    i_sync   = 1'b0;
    i_ready  = 1'b0;
    i_result = '0;
    repeat (3) clock_cycle();
    n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", o_valid); end
    n_checks++; if (o_last !== 1'b0) begin n_fail++; $display("FAIL reset_last: got %b want 0", o_last); end
    n_checks++; if (o_bin !== '0) begin n_fail++; $display("FAIL reset_bin: got %0d want 0", o_bin); end
    n_checks++; if (o_data !== '0) begin n_fail++; $display("FAIL reset_data: got %h want 0", o_data); end
    n_checks++; if (o_overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b want 0", o_overflow); end
    n_checks++; if (o_drop_count !== '0) begin n_fail++; $display("FAIL reset_drop_count: got %0d want 0", o_drop_count); end
    i_reset = 1'b0;
    clock_cycle();
  endtask

  task automatic test_single_frame();
    i_ready = 1'b1;
    send_frame(0, 1'b0, 1'b1);
    clock_cycle();
    n_checks++; if (last_valid !== 1'b0) begin n_fail++; $display("FAIL latency_e0: got o_valid=%b want 0", last_valid); end
    clock_cycle();
    n_checks++; if (last_valid !== 1'b0) begin n_fail++; $display("FAIL latency_e1: got o_valid=%b want 0", last_valid); end
    clock_cycle();
    n_checks++; if (last_valid !== 1'b1) begin n_fail++; $display("FAIL latency_e2: got o_valid=%b want 1", last_valid); end
    repeat (N - 1) clock_cycle();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL single_throughput: got %0d beats left, want 0", exp_q.size());
    end
    clock_cycle();
    n_checks++; if (last_valid !== 1'b0) begin n_fail++; $display("FAIL single_after: got o_valid=%b want 0", last_valid); end
    drain(50, "single");
  endtask

  task automatic test_overflow();
    ovf_seen = 0;
    i_ready  = 1'b0;
    send_frame(1, 1'b0, 1'b1);
    send_frame(2, 1'b0, 1'b1);
    send_frame(3, 1'b0, 1'b0);
    exp_drops++;
    repeat (5) clock_cycle();
    n_checks++; if (ovf_seen != 1) begin n_fail++; $display("FAIL overflow_pulses: got %0d want 1", ovf_seen); end
    n_checks++; if (o_drop_count !== CNTW'(exp_drops)) begin n_fail++; $display("FAIL overflow_count: got %0d want %0d", o_drop_count, exp_drops); end
    i_ready = 1'b1;
    drain(100, "overflow");
  endtask

  task automatic test_ce_toggle();
    ovf_seen = 0;
    i_ready  = 1'b1;
    send_frame(6, 1'b1, 1'b1);
    drain(60, "ce_toggle");
    n_checks++; if (ovf_seen != 0) begin n_fail++; $display("FAIL ce_toggle_overflow: got %0d want 0", ovf_seen); end
  endtask

  task automatic test_resync();
    i_ready = 1'b1;
    for (int b = 0; b < 7; b++) send_sample(4, b, b == 0, 1'b0);
    send_frame(5, 1'b0, 1'b1);
    drain(60, "resync");
    n_checks++; if (o_drop_count !== CNTW'(exp_drops)) begin n_fail++; $display("FAIL resync_count: got %0d want %0d", o_drop_count, exp_drops); end
  endtask

  task automatic test_random_ready();
    ovf_seen   = 0;
    rand_ready = 1'b1;
    for (int f = 0; f < 20; f++) begin
      send_frame(10 + f, 1'b1, 1'b1);
      repeat (16) idle_cycle();
    end
    rand_ready = 1'b0;
    i_ready    = 1'b1;
    drain(200, "random_ready");
    n_checks++; if (ovf_seen != 0) begin n_fail++; $display("FAIL random_overflow: got %0d want 0", ovf_seen); end
    n_checks++; if (o_drop_count !== CNTW'(exp_drops)) begin n_fail++; $display("FAIL random_count: got %0d want %0d", o_drop_count, exp_drops); end
  endtask

  task automatic test_reset_mid_drain();
    int k;
    bit hit = 1'b0;
    i_ready = 1'b1;
    send_frame(30, 1'b0, 1'b1);
    // Frame 31 fills the other bank while frame 30 drains; it is never expected.
    for (k = 0; k < N && !hit; k++) begin
      send_sample(31, k, k == 0, 1'b0);
      hit = last_acc && (last_acc_bin == LGWIDTH'(4));
    end
    n_checks++;
    if (!hit) begin
      n_fail++;
      $display("FAIL mid_drain_reach_bin4: got no bin 4 accept, want one");
    end
    i_reset = 1'b1;
    i_ready = 1'b0;
    i_ce    = 1'b0;
    clock_cycle();
    exp_q.delete();
    held_valid = 1'b0;
    in_frame   = 1'b0;
    exp_drops  = 0;
    i_reset    = 1'b0;
    n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL mid_reset_valid: got %b want 0", o_valid); end
    n_checks++; if (o_drop_count !== '0) begin n_fail++; $display("FAIL mid_reset_count: got %0d want 0", o_drop_count); end
    n_checks++; if (o_overflow !== 1'b0) begin n_fail++; $display("FAIL mid_reset_overflow: got %b want 0", o_overflow); end
    i_ready = 1'b1;
    for (int b = k; b < N; b++) send_sample(31, b, 1'b0, 1'b0);
    i_ce = 1'b0;
    repeat (20) clock_cycle();
    send_frame(32, 1'b0, 1'b1);
    drain(60, "post_reset");
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_overflow();
    test_ce_toggle();
    test_resync();
    test_random_ready();
    test_reset_mid_drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fft_frame_capture.md
# fft_frame_capture

Frame-aligned consumer for the pipelined 16-point FFT output stream. It watches the FFT result/sync stream qualified by the FFT clock enable and captures whole 16-bin frames, starting at the sync-marked bin 0, into a two-bank ping-pong buffer. It drains completed frames in natural bin order over a valid/ready stream to downstream magnitude and host-readout logic. Frames that arrive while both banks are full are dropped whole and counted.

## Interface
- OWIDTH, 11: bits per real/imag component of the FFT result.
- LGWIDTH, 4: log2 of FFT size; N = 2**LGWIDTH bins per frame.
- CNTW, 16: width of the dropped-frame counter.

- i_clk  in  1  clock; all logic on the rising edge.
- i_reset  in  1  reset, synchronous, active-high.
- i_ce  in  1  FFT clock enable; an input sample is valid only when high.
- i_result  in  2*OWIDTH  FFT result; real in the high half, imaginary in the low half.
- i_sync  in  1  high with bin 0 of each frame; qualified by i_ce.
- o_valid  out  1  output beat valid.
- i_ready  in  1  downstream accepts the beat when o_valid && i_ready.
- o_data  out  2*OWIDTH  captured bin, same format as i_result.
- o_bin  out  LGWIDTH  bin index of o_data.
- o_last  out  1  high on bin N-1 of a frame.
- o_overflow  out  1  one-cycle pulse when a frame is dropped.
- o_drop_count  out  CNTW  saturating count of dropped frames.

## Operation
- Storage: 2 banks of N entries each, 2*OWIDTH bits wide. Per-bank full flags. Write-bank pointer wb and read-bank pointer rb, both toggling.
- Write FSM states: W_IDLE, W_FILL.
  - W_IDLE: ignore samples until i_ce && i_sync.
    - If full[wb]==0: write to addr 0, set wptr=1, go to W_FILL.
    - Else: drop the frame, pulse o_overflow, increment o_drop_count (saturate at all-ones), stay in W_IDLE.
  - W_FILL: on each i_ce, write at wptr and increment wptr.
    - Write at wptr==N-1: set full[wb], toggle wb, go to W_IDLE.
    - i_ce && i_sync while wptr!=0: resync. Discard the partial frame, write this sample at addr 0 of the same bank, set wptr=1.
  - i_ce low: no write, no pointer change.
- Read FSM states: R_IDLE, R_STREAM.
  - R_IDLE: when full[rb], start reading addr 0 of bank rb.
  - R_STREAM: emit bins 0..N-1 in order. The beat with o_bin==N-1 asserts o_last.
  - When the o_last beat is accepted: clear full[rb], toggle rb, return to R_IDLE.
- Output stream rules:
  - o_data, o_bin and o_last stay stable while o_valid && !i_ready.
  - o_valid never drops mid-frame except for reset.
- The read side runs every clock, independent of i_ce.
- Simultaneous events:
  - full[] is registered. A bank released on edge E is visible to a sync at edge E+1 or later. A sync sampled on edge E sees that bank still full and drops the frame.
  - Setting full[wb] and clearing full[rb] in the same cycle always refer to different banks; both take effect.
- Arithmetic: no data modification; the capture is bit-exact.

## Timing
- Reset values: o_valid=0, o_last=0, o_bin=0, o_data=0, o_overflow=0, o_drop_count=0; full[]=0, wb=rb=0; both FSMs idle.
- Reset mid-frame discards all buffered and partial data. The first frame after reset begins at the next sync.
- Latency: if bin N-1 is captured on edge E, o_valid for bin 0 rises after edge E+2 (with R_IDLE and an empty output).
- Throughput:
  - With i_ready held high, one beat per clock within a frame.
  - At most 2 idle cycles between back-to-back buffered frames.
- Backpressure: the read path includes a one-entry skid, so a 1-cycle memory read latency never loses or duplicates a beat.

## Structure
- Shared package fft_pkg holds:
  - OWIDTH, LGWIDTH and N;
  - the write-state and read-state enums;
  - the result-word typedef for {real, imag}.
- Sub-module fft_capture_bank: simple dual-port RAM of 2*N x 2*OWIDTH, one write port and one registered read port, addressed {bank, bin}.
- Top level holds both FSMs, the full flags, the skid register and the counter.

## Test plan
- Single frame, i_ce=1, i_result = {bin, ~bin} for bins 0..15, i_ready=1 -> 16 consecutive beats o_bin 0..15 with matching data, o_last on bin 15, o_valid rising 2 clocks after bin 15 is captured.
- Continuous frames, i_ready=0 -> frames 1 and 2 buffered, frame 3 dropped. o_overflow pulses once and o_drop_count=1. After i_ready=1, frames 1 and 2 drain in order.
- i_ce toggling 1/0/1/0 during input -> exact 16-bin capture, no gaps counted as samples.
- Resync: i_sync reasserted at bin 7 -> no partial frame output. The frame starting at the new sync is emitted intact.
- Random i_ready (50%) over 20 frames -> every beat accepted exactly once, data stable while stalled, no overflow when production rate is lower than drain rate.
- i_reset asserted mid-drain at bin 5 -> o_valid=0 on the next cycle, counter 0, and the next frame after sync is captured normally.
